// File: rtl/sdatamem_hs.sv
`timescale 1ns/1ps
// rtl/sdatamem_hs.sv - handshaked byte-strobed data memory with a registered 1-cycle response
// Optional macro DMEM_MISALIGN_SPLIT_EN: word-crossing misaligned accesses are split over two cycles.

module sdatamem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int WORDS  = MEM_BYTES / BYTES;
  localparam int LANE_W = $clog2(BYTES);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int SH_W   = LANE_W + 3;
  localparam int AW1    = ADDR_WIDTH + 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif
  localparam int SW = SPAN * DATA_WIDTH;
  localparam int SB = SPAN * BYTES;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, SPLIT} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t state, next_state;
  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [LANE_W-1:0]     lane;
  logic [WIDX_W-1:0]     widx;
  logic [3:0]            sz_bytes;
  logic [SH_W-1:0]       sh;
  logic                  range_err;
  logic                  size_err;
  logic                  err;
  logic                  accept;
  logic                  wr_en;
  logic [SW-1:0]         wr_data;
  logic [SB-1:0]         wr_mask;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [1:0] size,
                                                   input logic uns);
    logic [DATA_WIDTH-1:0] mask;
    logic sign;
    int nbits;
    nbits = 8 << size;
    if (nbits >= DATA_WIDTH) return d;
    mask = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
    sign = d[nbits-1];
    return (!uns && sign) ? (d | ~mask) : (d & mask);
  endfunction

  assign lane      = req_addr_i[LANE_W-1:0];
  assign widx      = req_addr_i[LANE_W +: WIDX_W];
  assign sz_bytes  = 4'd1 << req_size_i;
  assign sh        = {lane, 3'b000};
  // Full-width address compare, so high address bits can never alias into storage
  assign range_err = ({1'b0, req_addr_i} + AW1'(sz_bytes)) > AW1'(MEM_BYTES);
  assign size_err  = (req_size_i == 2'b11) && (DATA_WIDTH == 32);
  assign wr_data   = SW'(req_wdata_i) << sh;
  assign wr_mask   = SB'((9'd1 << sz_bytes) - 9'd1) << lane;
  assign load_data = extend(mem[widx] >> sh, req_size_i, req_unsigned_i);
  assign wr_en     = accept && req_we_i && !err;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic                  crossing;
  logic                  split_start;
  logic [WIDX_W-1:0]     sp_idx;
  logic [SH_W-1:0]       sp_sh;
  logic [1:0]            sp_size;
  logic                  sp_uns;
  logic                  sp_we;
  logic [DATA_WIDTH-1:0] sp_data;
  logic [BYTES-1:0]      sp_mask;
  logic [DATA_WIDTH-1:0] lo_word;

  assign crossing    = (5'(lane) + 5'(sz_bytes)) > 5'(BYTES);
  assign err         = range_err | size_err;
  assign split_start = accept && !err && crossing;
`else
  logic misaligned;

  assign misaligned = (req_addr_i[2:0] & 3'(sz_bytes - 4'd1)) != 3'd0;
  assign err        = range_err | size_err | misaligned;
`endif

  always_comb begin
    next_state  = state;
    req_ready_o = (state == IDLE) && (!rsp_valid_o || rsp_ready_i);
    accept      = req_valid_i && req_ready_o;
`ifdef DMEM_MISALIGN_SPLIT_EN
    case (state)
      IDLE:    if (split_start) next_state = SPLIT;
      SPLIT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (state == SPLIT) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= sp_we ? '0 :
                       extend(DATA_WIDTH'({mem[sp_idx], lo_word} >> sp_sh), sp_size, sp_uns);
        rsp_err_o   <= 1'b0;
      end else
`endif
      if (accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        rsp_valid_o <= !split_start;
`else
        rsp_valid_o <= 1'b1;
`endif
        rsp_rdata_o <= (req_we_i || err) ? '0 : load_data;
        rsp_err_o   <= err;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (wr_en && wr_mask[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (state == SPLIT && sp_we && sp_mask[b]) mem[sp_idx][8*b +: 8] <= sp_data[8*b +: 8];
`endif
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (accept) begin
      sp_idx  <= widx + WIDX_W'(1);
      sp_sh   <= sh;
      sp_size <= req_size_i;
      sp_uns  <= req_unsigned_i;
      sp_we   <= req_we_i;
      sp_data <= wr_data[SW-1:DATA_WIDTH];
      sp_mask <= wr_mask[SB-1:BYTES];
      lo_word <= mem[widx];
    end
`endif
  end

endmodule
